// File: rtl/sigma_delta_modulator.sv
// sigma_delta_modulator
// First-order, single-bit, error-feedback sigma-delta modulator.
// A 17-bit signed integrator accumulates the difference between the
// incoming 16-bit PCM sample and the fed-back full-scale value chosen
// by the current output bit. The MSB of the integrator (inverted) is the
// bitstream, so the output is purely combinational from the register.
//
// Build option: define SDM_INPUT_REG_EN to place a register in front of
// the integrator. This adds one edge of latency from i_dataword_in to the
// integrator. The port list is the same in both builds.
module sigma_delta_modulator (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_dataword_in,
    output logic        o_data_out,
    output logic [16:0] o_delay_out
);

    // Integrator (delay) register, two's complement.
    logic [16:0] r_acc;

    // Sample actually used by the integrator on this edge.
    logic [15:0] w_x;

    // Feedback value selected by the current output bit, 18-bit two's complement.
    logic [17:0] w_fb;

    // Full-width sum, one guard bit above the integrator width.
    logic [17:0] w_sum;

    // Guard bit is never needed: the in-range result always fits 17 bits.
    logic        w_unused_carry;

`ifdef SDM_INPUT_REG_EN
    // Input register; the integrator sees last edge's sample.
    logic [15:0] r_sample;

    // Capture the incoming sample each edge and clear it on reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sample <= 16'd0;
        end else begin
            r_sample <= i_dataword_in;
        end
    end

    assign w_x = r_sample;
`else
    assign w_x = i_dataword_in;
`endif

    // A non-negative integrator means the output represents +full-scale.
    assign o_data_out  = ~r_acc[16];
    assign o_delay_out = r_acc;

    // +32768 when the output is 1, -32768 when it is 0.
    assign w_fb = o_data_out ? 18'h08000 : 18'h38000;

    // Sign-extend both operands to 18 bits before summing so that the
    // intermediate never wraps; only the low 17 bits are kept.
    assign w_sum = {r_acc[16], r_acc} + {{2{w_x[15]}}, w_x} - w_fb;

    assign w_unused_carry = w_sum[17];

    // Integrate input minus feedback every edge; reset discards all history.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= 17'd0;
        end else begin
            r_acc <= w_sum[16:0];
        end
    end

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// tb_sigma_delta_modulator
// Scoreboard bench for sigma_delta_modulator. Each driven edge pushes the
// expected integrator value and output bit computed from an integer model;
// after the edge the entry is popped and compared against the DUT. Fixed
// sequences from the modulator's known behaviour are also checked as
// literal tables in the default build. Compile with +define+SDM_INPUT_REG_EN
// to exercise the registered-input build.
module tb_sigma_delta_modulator;

    typedef struct {
        int    acc;
        int    dout;
        string tag;
    } exp_t;

    logic        clk;
    logic        i_reset;
    logic [15:0] i_dataword_in;
    logic        o_data_out;
    logic [16:0] o_delay_out;

    exp_t sbQ[$];

    int checkCount;
    int failCount;

    // Integer reference model state.
    int mAcc;
    int mReg;

    sigma_delta_modulator dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_dataword_in (i_dataword_in),
        .o_data_out    (o_data_out),
        .o_delay_out   (o_delay_out)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when the values differ.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one edge's inputs, predict the result, then compare after the edge.
    task automatic applyStimulus(input int x, input bit rst, input string tag);
        exp_t e;
        exp_t got;
        int   xEff;
        int   fb;
        @(negedge clk);
        i_reset       = rst;
        i_dataword_in = 16'(x);
        if (rst) begin
            mAcc = 0;
            mReg = 0;
        end else begin
`ifdef SDM_INPUT_REG_EN
            xEff = mReg;
`else
            xEff = x;
`endif
            fb   = (mAcc >= 0) ? 32768 : -32768;
            mAcc = mAcc + xEff - fb;
            mReg = x;
        end
        e.acc  = mAcc;
        e.dout = (mAcc >= 0) ? 1 : 0;
        e.tag  = tag;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        if (sbQ.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 0, 1);
        end else begin
            got = sbQ.pop_front();
            checkOutput({got.tag, "_acc"}, int'($signed(o_delay_out)), got.acc);
            checkOutput({got.tag, "_dout"}, int'(o_data_out), got.dout);
        end
    endtask

    initial begin
        int quarterTab[4];
        int ones;
        int rx;

        quarterTab[0] = -16384;
        quarterTab[1] = 32768;
        quarterTab[2] = 16384;
        quarterTab[3] = 0;

        checkCount    = 0;
        failCount     = 0;
        mAcc          = 0;
        mReg          = 0;
        i_reset       = 1'b1;
        i_dataword_in = 16'h0000;

        $display("[TB] sigma_delta_modulator bench start");

        // Reset with an arbitrary input present must still clear the integrator.
        applyStimulus(12345, 1'b1, "reset");
        checkOutput("reset_lit_acc", int'($signed(o_delay_out)), 0);
        checkOutput("reset_lit_dout", int'(o_data_out), 1);
        applyStimulus(-20000, 1'b1, "reset2");
        checkOutput("reset2_lit_acc", int'($signed(o_delay_out)), 0);

        // Zero input: integrator alternates -32768 / 0.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, "zero");
`ifndef SDM_INPUT_REG_EN
            checkOutput("zero_lit_acc", int'($signed(o_delay_out)), (i % 2 == 0) ? -32768 : 0);
            checkOutput("zero_lit_dout", int'(o_data_out), (i % 2 == 0) ? 0 : 1);
`endif
        end

        // Quarter scale: period-4 pattern, three ones out of four.
        applyStimulus(0, 1'b1, "reset_q");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16384, 1'b0, "quarter");
`ifndef SDM_INPUT_REG_EN
            checkOutput("quarter_lit_acc", int'($signed(o_delay_out)), quarterTab[i % 4]);
`endif
        end

        // Negative full scale: integrator pins at -65536, output stays 0.
        applyStimulus(0, 1'b1, "reset_nfs");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(-32768, 1'b0, "negfs");
`ifndef SDM_INPUT_REG_EN
            checkOutput("negfs_lit_acc", int'($signed(o_delay_out)), -65536);
            checkOutput("negfs_lit_dout", int'(o_data_out), 0);
`endif
        end

        // Positive full scale: -1, then 65534 counting down by one per edge.
        applyStimulus(0, 1'b1, "reset_pfs");
        for (int i = 0; i < 200; i++) begin
            applyStimulus(32767, 1'b0, "posfs");
`ifndef SDM_INPUT_REG_EN
            checkOutput("posfs_lit_acc", int'($signed(o_delay_out)), (i == 0) ? -1 : 65535 - i);
            checkOutput("posfs_lit_dout", int'(o_data_out), (i == 0) ? 0 : 1);
`endif
        end

        // Mid-stream reset: history discarded, quarter-scale pattern restarts.
        applyStimulus(0, 1'b1, "reset_mid0");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(16384, 1'b0, "mid_pre");
        end
        applyStimulus(16384, 1'b1, "mid_reset");
        checkOutput("mid_reset_lit_acc", int'($signed(o_delay_out)), 0);
        checkOutput("mid_reset_lit_dout", int'(o_data_out), 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16384, 1'b0, "mid_post");
`ifndef SDM_INPUT_REG_EN
            checkOutput("mid_post_lit_acc", int'($signed(o_delay_out)), quarterTab[i % 4]);
`endif
        end

        // Density: X = -16384 gives one 1 in every four outputs.
        applyStimulus(0, 1'b1, "reset_dens");
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(-16384, 1'b0, "density");
            ones += int'(o_data_out);
        end
        checkOutput("density_ones", ones, 16);

        // Random in-range samples, model-checked only.
        applyStimulus(0, 1'b1, "reset_rand");
        for (int i = 0; i < 60; i++) begin
            rx = int'($urandom_range(65535)) - 32768;
            applyStimulus(rx, 1'b0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
